// File: rtl/axi_tohost_multi.sv
// ---------------------------------------------------------------------------
// axi_tohost_multi
//
// AXI slave that collects "tohost" exit reports from several harts. Each hart
// owns one 64-bit tohost word at TOHOST_BASE + h*HART_STRIDE. A write with
// bit 0 set marks that hart as exited. Bits [15:1] carry its exit code, and a
// nonzero code means failure. The first nonzero code is latched. Reads always
// return zero with a single-beat response.
//
// Ports:
//   clk_i, rstn_i          clock and synchronous active-low reset
//   aw_*                   write address channel (one-entry buffer)
//   w_*                    write data channel (first beat kept, rest dropped)
//   b_*                    write response channel (always OKAY, echoed ID)
//   ar_*                   read address channel (one read outstanding)
//   r_*                    read data channel (zero data, last always set)
//   done_o                 sticky, every hart has reported exit
//   fail_o                 sticky, some hart reported a nonzero code
//   exit_code_o            first nonzero exit code, else 0
//   exit_mask_o            per-hart "exit reported" flags
// ---------------------------------------------------------------------------
module axi_tohost_multi #(
  parameter int                    DATA_WIDTH  = 512,
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    ID_WIDTH    = 4,
  parameter int                    N_HARTS     = 4,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_BASE = 'h8000_1000,
  parameter int                    HART_STRIDE = 64
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ID_WIDTH-1:0]     ar_id_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [ID_WIDTH-1:0]     r_id_o,
  output logic                    r_last_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [14:0]             exit_code_o,
  output logic [N_HARTS-1:0]      exit_mask_o
);

  localparam int LANES = DATA_WIDTH / 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    BRESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    awReady_q;
  logic [ADDR_WIDTH-1:0]   awAddr_q;
  logic [ID_WIDTH-1:0]     awId_q;
  logic                    wReady_q;
  logic                    wFirst_q;
  logic [DATA_WIDTH-1:0]   wData_q;
  logic [DATA_WIDTH/8-1:0] wStrb_q;
  logic                    bValid_q;
  logic [ID_WIDTH-1:0]     bId_q;
  logic [N_HARTS-1:0]      exitMask_q;
  logic                    fail_q;
  logic [14:0]             exitCode_q;
  logic                    done_q;
  logic                    arReady_q;
  logic                    rValid_q;
  logic [ID_WIDTH-1:0]     rId_q;

  logic                    bHandshake;
  logic [ADDR_WIDTH-1:0]   laneSel_d;
  logic [15:0]             laneVal_d;
  logic                    laneStrbOk_d;
  logic [N_HARTS-1:0]      hitMask_d;
  logic                    exitValid_d;

  assign bHandshake = bValid_q && b_ready_i;

  // AW buffer: holds one address until its write response has been taken.
  // Buffers only release on the B handshake, so a new AW cannot overlap.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      awReady_q <= 1'b1;
      awAddr_q  <= '0;
      awId_q    <= '0;
    end else if (bHandshake) begin
      awReady_q <= 1'b1;
    end else if (aw_valid_i && awReady_q) begin
      awReady_q <= 1'b0;
      awAddr_q  <= aw_addr_i;
      awId_q    <= aw_id_i;
    end
  end

  // W buffer: keep only the first beat of a burst, keep accepting and
  // discarding beats until the last one. The buffer is full (ready low)
  // only after the last beat has been taken.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wReady_q <= 1'b1;
      wFirst_q <= 1'b1;
      wData_q  <= '0;
      wStrb_q  <= '0;
    end else if (bHandshake) begin
      wReady_q <= 1'b1;
      wFirst_q <= 1'b1;
    end else if (w_valid_i && wReady_q) begin
      if (wFirst_q) begin
        wData_q <= w_data_i;
        wStrb_q <= w_strb_i;
      end
      wFirst_q <= 1'b0;
      if (w_last_i) begin
        wReady_q <= 1'b0;
      end
    end
  end

  // Decode the buffered write: pick the 64-bit lane addressed by the low
  // address bits and match the address against every hart's tohost word.
  // The comparison is done one bit wider so a base plus offset that would
  // wrap the address space can never alias a low address.
  always_comb begin
    laneSel_d    = (awAddr_q >> 3) & ADDR_WIDTH'(LANES - 1);
    laneVal_d    = '0;
    laneStrbOk_d = 1'b0;
    hitMask_d    = '0;
    for (int k = 0; k < LANES; k++) begin
      if (laneSel_d == ADDR_WIDTH'(k)) begin
        laneVal_d    = wData_q[64*k +: 16];
        laneStrbOk_d = &wStrb_q[8*k +: 8];
      end
    end
    for (int h = 0; h < N_HARTS; h++) begin
      if ({1'b0, awAddr_q} ==
          ({1'b0, TOHOST_BASE} + (ADDR_WIDTH+1)'(h * HART_STRIDE))) begin
        hitMask_d[h] = 1'b1;
      end
    end
    exitValid_d = (|hitMask_d) && laneStrbOk_d && laneVal_d[0];
  end

  // Write FSM and exit status. EXEC applies the decoded write for one cycle.
  // ORing the hit into the mask makes a repeat exit harmless to the mask,
  // while it may still latch the first failure code. done follows the mask
  // one cycle later and is sticky.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      bValid_q   <= 1'b0;
      bId_q      <= '0;
      exitMask_q <= '0;
      fail_q     <= 1'b0;
      exitCode_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_q | (&exitMask_q);
      case (state_q)
        IDLE: begin
          if (!awReady_q && !wReady_q) begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (exitValid_d) begin
            exitMask_q <= exitMask_q | hitMask_d;
            if ((laneVal_d[15:1] != 15'd0) && !fail_q) begin
              fail_q     <= 1'b1;
              exitCode_q <= laneVal_d[15:1];
            end
          end
          bValid_q <= 1'b1;
          bId_q    <= awId_q;
          state_q  <= BRESP;
        end
        BRESP: begin
          if (b_ready_i) begin
            bValid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read path: one read in flight, answered with zero data the cycle after
  // the AR handshake. It shares nothing with the write path.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      arReady_q <= 1'b1;
      rValid_q  <= 1'b0;
      rId_q     <= '0;
    end else if (rValid_q) begin
      if (r_ready_i) begin
        rValid_q  <= 1'b0;
        arReady_q <= 1'b1;
      end
    end else if (ar_valid_i && arReady_q) begin
      arReady_q <= 1'b0;
      rValid_q  <= 1'b1;
      rId_q     <= ar_id_i;
    end
  end

  assign aw_ready_o  = awReady_q;
  assign w_ready_o   = wReady_q;
  assign b_valid_o   = bValid_q;
  assign b_id_o      = bId_q;
  assign b_resp_o    = 2'b00;
  assign ar_ready_o  = arReady_q;
  assign r_valid_o   = rValid_q;
  assign r_id_o      = rId_q;
  assign r_data_o    = '0;
  assign r_last_o    = 1'b1;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign exit_code_o = exitCode_q;
  assign exit_mask_o = exitMask_q;

endmodule

// File: tb/tb_axi_tohost_multi.sv
// ---------------------------------------------------------------------------
// tb_axi_tohost_multi
//
// Directed bench for axi_tohost_multi. Two instances share one stimulus
// stream: dut1 is a single-hart default configuration, dut4 has four harts
// with a 72-byte stride so that successive harts land in different 64-bit
// lanes of the 512-bit bus. Non-addressed lanes are filled with a pattern
// that would look like a failing exit if it were ever picked by mistake.
// ---------------------------------------------------------------------------
module tb_axi_tohost_multi;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         awValid = 1'b0;
  logic [63:0]  awAddr = '0;
  logic [3:0]   awId = '0;
  logic         wValid = 1'b0;
  logic [511:0] wData = '0;
  logic [63:0]  wStrb = '0;
  logic         wLast = 1'b0;
  logic         bReady = 1'b0;
  logic         arValid = 1'b0;
  logic [3:0]   arId = '0;
  logic         rReady = 1'b0;

  logic         awReady4, wReady4, bValid4, arReady4, rValid4, rLast4;
  logic         done4, fail4;
  logic [3:0]   bId4, rId4, mask4;
  logic [1:0]   bResp4;
  logic [511:0] rData4;
  logic [14:0]  code4;

  logic         awReady1, wReady1, bValid1, arReady1, rValid1, rLast1;
  logic         done1, fail1;
  logic [3:0]   bId1, rId1;
  logic [0:0]   mask1;
  logic [1:0]   bResp1;
  logic [511:0] rData1;
  logic [14:0]  code1;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [63:0] FILL = 64'hDEAD_0000_0000_00FF;

  axi_tohost_multi #(.N_HARTS(4), .HART_STRIDE(72)) dut4 (
    .clk_i(clk), .rstn_i(rstn),
    .aw_valid_i(awValid), .aw_ready_o(awReady4), .aw_addr_i(awAddr), .aw_id_i(awId),
    .w_valid_i(wValid), .w_ready_o(wReady4), .w_data_i(wData), .w_strb_i(wStrb),
    .w_last_i(wLast),
    .b_valid_o(bValid4), .b_ready_i(bReady), .b_id_o(bId4), .b_resp_o(bResp4),
    .ar_valid_i(arValid), .ar_ready_o(arReady4), .ar_id_i(arId),
    .r_valid_o(rValid4), .r_ready_i(rReady), .r_data_o(rData4), .r_id_o(rId4),
    .r_last_o(rLast4),
    .done_o(done4), .fail_o(fail4), .exit_code_o(code4), .exit_mask_o(mask4)
  );

  axi_tohost_multi #(.N_HARTS(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .aw_valid_i(awValid), .aw_ready_o(awReady1), .aw_addr_i(awAddr), .aw_id_i(awId),
    .w_valid_i(wValid), .w_ready_o(wReady1), .w_data_i(wData), .w_strb_i(wStrb),
    .w_last_i(wLast),
    .b_valid_o(bValid1), .b_ready_i(bReady), .b_id_o(bId1), .b_resp_o(bResp1),
    .ar_valid_i(arValid), .ar_ready_o(arReady1), .ar_id_i(arId),
    .r_valid_o(rValid1), .r_ready_i(rReady), .r_data_o(rData1), .r_id_o(rId1),
    .r_last_o(rLast1),
    .done_o(done1), .fail_o(fail1), .exit_code_o(code1), .exit_mask_o(mask1)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Places v in one lane and the decoy pattern in all others.
  function automatic logic [511:0] mkData(input int lane, input logic [63:0] v);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = (k == lane) ? v : FILL;
    return d;
  endfunction

  function automatic logic [63:0] mkStrb(input int lane, input logic [7:0] laneStrb);
    logic [63:0] s;
    s = '1;
    s[8*lane +: 8] = laneStrb;
    return s;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    repeat (2) stepCycle();
    rstn = 1'b1;
  endtask

  task automatic sendAw(input logic [63:0] addr, input logic [3:0] id, input int delay);
    bit hs;
    int cnt;
    repeat (delay) stepCycle();
    awAddr = addr;
    awId = id;
    awValid = 1'b1;
    hs = 1'b0;
    cnt = 0;
    while (!hs && cnt < 50) begin
      hs = awReady4;
      stepCycle();
      cnt++;
    end
    awValid = 1'b0;
    if (!hs) checkOutput("awTimeout", 64'd0, 64'd1);
  endtask

  task automatic sendW(input logic [511:0] data0, input logic [63:0] strb0,
                       input logic [511:0] laterData, input int beats, input int delay);
    bit hs;
    int cnt;
    repeat (delay) stepCycle();
    for (int b = 0; b < beats; b++) begin
      wData = (b == 0) ? data0 : laterData;
      wStrb = (b == 0) ? strb0 : '1;
      wLast = (b == beats - 1);
      wValid = 1'b1;
      hs = 1'b0;
      cnt = 0;
      while (!hs && cnt < 50) begin
        hs = wReady4;
        stepCycle();
        cnt++;
      end
      if (!hs) checkOutput("wTimeout", 64'd0, 64'd1);
    end
    wValid = 1'b0;
    wLast = 1'b0;
  endtask

  // One write transaction: AW and W issued concurrently with optional lead.
  task automatic applyStimulus(input logic [63:0] addr, input logic [3:0] id,
                               input logic [511:0] data0, input logic [63:0] strb0,
                               input logic [511:0] laterData, input int beats,
                               input int awDelay, input int wDelay);
    fork
      sendAw(addr, id, awDelay);
      sendW(data0, strb0, laterData, beats, wDelay);
    join
  endtask

  // Waits (bounded) for the write response, checks its latency from the
  // moment both buffers are full, its ID and OKAY, and that it holds while
  // bReady stays low.
  task automatic waitB(input string tag, input logic [3:0] expId, input int hold);
    int lat;
    lat = 0;
    while (!bValid4 && lat < 20) begin
      stepCycle();
      lat++;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'd2);
    checkOutput({tag, "_bId"}, 64'(bId4), 64'(expId));
    checkOutput({tag, "_bResp"}, 64'(bResp4), 64'd0);
    if (hold > 0) begin
      repeat (hold) stepCycle();
      checkOutput({tag, "_bHeld"}, 64'(bValid4), 64'd1);
    end
  endtask

  task automatic ackB(input string tag);
    bReady = 1'b1;
    stepCycle();
    bReady = 1'b0;
    checkOutput({tag, "_bDrop"}, 64'(bValid4), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_awReady"}, 64'(awReady4), 64'd1);
    checkOutput({tag, "_wReady"}, 64'(wReady4), 64'd1);
    checkOutput({tag, "_arReady"}, 64'(arReady4), 64'd1);
    checkOutput({tag, "_bValid"}, 64'(bValid4), 64'd0);
    checkOutput({tag, "_rValid"}, 64'(rValid4), 64'd0);
    checkOutput({tag, "_bId"}, 64'(bId4), 64'd0);
    checkOutput({tag, "_rId"}, 64'(rId4), 64'd0);
    checkOutput({tag, "_done"}, 64'(done4), 64'd0);
    checkOutput({tag, "_fail"}, 64'(fail4), 64'd0);
    checkOutput({tag, "_code"}, 64'(code4), 64'd0);
    checkOutput({tag, "_mask"}, 64'(mask4), 64'd0);
  endtask

  initial begin
    doReset();
    checkResetState("rst");

    // Single hart: exit 0x1 at the base gives done without failure.
    applyStimulus(64'h8000_1000, 4'h3, mkData(0, 64'h1), '1, '0, 1, 0, 0);
    waitB("h1", 4'h3, 0);
    ackB("h1");
    checkOutput("h1_done", 64'(done1), 64'd1);
    checkOutput("h1_fail", 64'(fail1), 64'd0);
    checkOutput("h1_code", 64'(code1), 64'd0);
    checkOutput("h1_mask", 64'(mask1), 64'd1);
    checkOutput("h1_mask4", 64'(mask4), 64'h1);
    checkOutput("h1_done4", 64'(done4), 64'd0);

    // Four harts in lanes 0..3; hart 2 reports code 3.
    doReset();
    applyStimulus(64'h8000_1000, 4'h1, mkData(0, 64'h1), '1, '0, 1, 0, 0);
    waitB("m0", 4'h1, 0);
    ackB("m0");
    checkOutput("m0_mask", 64'(mask4), 64'h1);
    applyStimulus(64'h8000_1048, 4'h2, mkData(1, 64'h1), '1, '0, 1, 0, 0);
    waitB("m1", 4'h2, 0);
    ackB("m1");
    checkOutput("m1_mask", 64'(mask4), 64'h3);
    checkOutput("m1_fail", 64'(fail4), 64'd0);
    applyStimulus(64'h8000_1090, 4'h4, mkData(2, 64'h7), '1, '0, 1, 0, 0);
    waitB("m2", 4'h4, 0);
    ackB("m2");
    checkOutput("m2_mask", 64'(mask4), 64'h7);
    checkOutput("m2_fail", 64'(fail4), 64'd1);
    checkOutput("m2_code", 64'(code4), 64'd3);
    checkOutput("m2_done", 64'(done4), 64'd0);
    applyStimulus(64'h8000_10D8, 4'h5, mkData(3, 64'h1), '1, '0, 1, 0, 0);
    waitB("m3", 4'h5, 0);
    checkOutput("m3_mask", 64'(mask4), 64'hF);
    checkOutput("m3_doneEarly", 64'(done4), 64'd0);
    ackB("m3");
    checkOutput("m3_done", 64'(done4), 64'd1);
    // A later code (5) must not replace the first one.
    applyStimulus(64'h8000_1048, 4'h6, mkData(1, 64'h0B), '1, '0, 1, 0, 0);
    waitB("m4", 4'h6, 0);
    ackB("m4");
    checkOutput("m4_code", 64'(code4), 64'd3);
    checkOutput("m4_done", 64'(done4), 64'd1);

    // Misses and ignored writes leave status alone.
    doReset();
    applyStimulus(64'h8000_1008, 4'h7, mkData(1, 64'h1), '1, '0, 1, 0, 0);
    waitB("miss8", 4'h7, 0);
    ackB("miss8");
    checkOutput("miss8_mask", 64'(mask4), 64'h0);
    applyStimulus(64'h8000_1120, 4'h8, mkData(4, 64'h1), '1, '0, 1, 0, 0);
    waitB("missH4", 4'h8, 0);
    ackB("missH4");
    checkOutput("missH4_mask", 64'(mask4), 64'h0);
    applyStimulus(64'h8000_1000, 4'h9, mkData(0, 64'h1), mkStrb(0, 8'h0F), '0, 1, 0, 0);
    waitB("strb", 4'h9, 0);
    ackB("strb");
    checkOutput("strb_mask", 64'(mask4), 64'h0);
    applyStimulus(64'h8000_1000, 4'h9, mkData(0, 64'h6), '1, '0, 1, 0, 0);
    waitB("bit0", 4'h9, 0);
    ackB("bit0");
    checkOutput("bit0_mask", 64'(mask4), 64'h0);
    checkOutput("bit0_fail", 64'(fail4), 64'd0);

    // W leads AW by 5 cycles with a 4-beat burst; later beats carry code 9
    // and must be dropped. Response is held for 3 cycles.
    applyStimulus(64'h8000_1048, 4'hA, mkData(1, 64'h1), '1,
                  {8{64'h13}}, 4, 5, 0);
    waitB("burst", 4'hA, 3);
    ackB("burst");
    checkOutput("burst_mask", 64'(mask4), 64'h2);
    checkOutput("burst_fail", 64'(fail4), 64'd0);
    // Repeat exit from hart 1 may still latch the first failure (code 2).
    applyStimulus(64'h8000_1048, 4'hB, mkData(1, 64'h5), '1, '0, 1, 0, 0);
    waitB("rep", 4'hB, 0);
    ackB("rep");
    checkOutput("rep_mask", 64'(mask4), 64'h2);
    checkOutput("rep_fail", 64'(fail4), 64'd1);
    checkOutput("rep_code", 64'(code4), 64'd2);

    // Read during an outstanding write response, then reset in BRESP.
    applyStimulus(64'h8000_1000, 4'h6, mkData(0, 64'h1), '1, '0, 1, 0, 0);
    waitB("rd", 4'h6, 0);
    checkOutput("rd_mask", 64'(mask4), 64'h3);
    checkOutput("rd_arReady", 64'(arReady4), 64'd1);
    arId = 4'h5;
    arValid = 1'b1;
    stepCycle();
    arValid = 1'b0;
    checkOutput("rd_rValid", 64'(rValid4), 64'd1);
    checkOutput("rd_rId", 64'(rId4), 64'h5);
    checkOutput("rd_rData", 64'(|rData4), 64'd0);
    checkOutput("rd_rLast", 64'(rLast4), 64'd1);
    checkOutput("rd_arBusy", 64'(arReady4), 64'd0);
    checkOutput("rd_bStill", 64'(bValid4), 64'd1);
    stepCycle();
    checkOutput("rd_rHeld", 64'(rValid4), 64'd1);
    rReady = 1'b1;
    stepCycle();
    rReady = 1'b0;
    checkOutput("rd_rDrop", 64'(rValid4), 64'd0);
    checkOutput("rd_arBack", 64'(arReady4), 64'd1);
    rstn = 1'b0;
    stepCycle();
    checkResetState("bresp_rst");
    rstn = 1'b1;
    stepCycle();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
